alu_exec_unit: RTL
==================

# alu_exec_unit

Execute-stage ALU with valid/ready handshakes, sitting directly downstream of the ALU control decoder. It consumes the 5-bit ALU control code plus two operands, completes add/sub/compare/logic operations in one cycle, and performs shifts with a bit-serial shifter (one bit per cycle). It holds each result in an output register until the memory/writeback stage takes it.

## Interface
- XLEN, 32, operand/result width; shift amount is op_b[4:0]; only 32 is supported.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  upstream offers an operation.
- in_ready  output  1  unit accepts an operation this cycle.
- alu_ctrl  input  5  control code {aluop2, func75, func3}; bit 4 is ignored by this unit.
- op_a  input  XLEN  first operand; the value shifted for shift ops.
- op_b  input  XLEN  second operand; bits [4:0] are the shift amount.
- flush  input  1  synchronous pipeline kill.
- out_valid  output  1  result register holds a valid result.
- out_ready  input  1  downstream consumes the result.
- result  output  XLEN  registered result.
- zero  output  1  registered, equals (result == 0).
- busy  output  1  high while a serial shift is in progress.

## Operation
- Decode uses alu_ctrl[3:0]:
  - 0000 add.
  - 1000 sub.
  - x001 sll.
  - x010 slt (signed; result 0 or 1, zero-extended).
  - x011 sltu.
  - x100 xor.
  - 0101 srl.
  - 1101 sra.
  - x110 or.
  - x111 and.
- Bit 3 matters only for 000 and 101.
- Arithmetic wraps modulo 2^XLEN; there are no overflow flags.
- FSM states:
  - IDLE: accepts when in_valid && in_ready.
    - Non-shift op, or shift with shamt=0: compute combinationally, write result/zero, set out_valid; stay in IDLE.
    - Shift with shamt=k≥1: load the work register with op_a and cnt with k; go to SHIFT.
  - SHIFT: each cycle, shift the work register one bit and decrement cnt.
    - sll fills with 0; srl fills with 0; sra fills with the stored sign bit (op_a[XLEN-1] captured at accept).
    - On the step where cnt==1, write the shifted value to result/zero, set out_valid, and return to IDLE.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- Output slot:
  - out_valid clears when out_ready is high and no new result is written that edge.
  - While out_valid && !out_ready, result/zero/out_valid hold unchanged.
- The output slot is always empty during SHIFT, because accept required it to drain. The final shift step therefore never stalls.
- flush: at the next edge, state→IDLE, cnt→0, out_valid→0. flush wins over a simultaneous accept or final shift step. Result/zero keep their value but are invalid.
- Reset (async): state IDLE, cnt 0, work register 0, out_valid 0, result 0, zero 1, busy 0, in_ready 1 after release.

## Timing
- Accept at edge N, non-shift or shamt=0: out_valid visible in cycle N+1 (1-cycle latency).
- Shift with shamt=k≥1: busy high in cycles N+1..N+k; out_valid visible in cycle N+k+1 (latency 1+k; worst case 32).
- Back-to-back single-cycle ops with out_ready held high sustain one op per cycle.
- Shifts block new input until the result is written.
- in_ready is 0 during SHIFT and while a result is stalled.
- in_ready is combinational from state, out_valid, out_ready and flush. No other combinational input→output paths exist.
- Reset asserted mid-shift aborts immediately. The first accept is possible in the first cycle after release.

## Test plan
- Add/sub: ctrl 00000, op_a=0x7FFFFFFF, op_b=1 → result 0x80000000 after 1 cycle. Then ctrl 01000, op_a=5, op_b=5 → result 0, zero=1.
- Compares: slt with op_a=0xFFFFFFFF, op_b=1 → 1. sltu with the same operands → 0. Both complete at 1 op/cycle with out_ready held high.
- Serial shifts:
  - sra, op_a=0x80000000, shamt=4 → 0xF8000000; busy for 4 cycles; out_valid on cycle 5.
  - srl with the same inputs → 0x08000000.
  - sll, op_a=1, shamt=31 → 0x80000000 after 32 cycles.
- shamt=0: sll, op_a=0x1234 → 0x1234 with 1-cycle latency; busy never asserts.
- Backpressure: hold out_ready=0 for 3 cycles after a result → result/out_valid stable and in_ready=0. Release → next op accepted in the same cycle as the drain.
- Flush/reset: flush at cycle 2 of an sll with shamt=10 → out_valid never rises, in_ready=1 next cycle. Async rst mid-shift → out_valid=0, zero=1 immediately.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with valid/ready handshakes.
// Single-cycle add/sub/compare/logic ops; shifts are done bit-serially,
// one bit per cycle, in a work register. Each result is held in an output
// register until downstream takes it.
//
// state | meaning
// IDLE  | ready for a new op (if the output slot is free); single-cycle ops finish here
// SHIFT | serial shift running; cnt holds the steps left, terminal count is cnt==1
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state, state_next;
    logic [4:0]      cnt;
    logic [XLEN-1:0] work;
    logic            sign_bit;
    logic            shift_left;
    logic            shift_arith;

    logic [2:0]      func3;
    logic            alt;
    logic [4:0]      shamt;
    logic            is_shift;
    logic            accept;
    logic            load_shift;
    logic            write_now;
    logic [XLEN-1:0] alu_value;
    logic [XLEN-1:0] work_shifted;
    logic [XLEN-1:0] write_value;

    // aluop2 (bit 4) carries no meaning for this unit
    logic ctrl_unused;
    assign ctrl_unused = alu_ctrl[4];

    assign func3    = alu_ctrl[2:0];
    assign alt      = alu_ctrl[3];
    assign shamt    = op_b[4:0];
    assign is_shift = (func3 == 3'b001) || (func3 == 3'b101);
    assign in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;
    assign busy     = (state == SHIFT);

    // Single-cycle operation result; shifts pass op_a through for shamt==0
    always_comb begin
        alu_value = '0;
        case (func3)
            3'b000:  alu_value = alt ? (op_a - op_b) : (op_a + op_b);
            3'b010:  alu_value = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            3'b011:  alu_value = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            3'b100:  alu_value = op_a ^ op_b;
            3'b110:  alu_value = op_a | op_b;
            3'b111:  alu_value = op_a & op_b;
            default: alu_value = op_a;
        endcase
    end

    // One-bit shift step of the work register
    always_comb begin
        if (shift_left)
            work_shifted = {work[XLEN-2:0], 1'b0};
        else
            work_shifted = {shift_arith & sign_bit, work[XLEN-1:1]};
    end

    // Next-state and control decode; flush overrides any accept or final step
    always_comb begin
        state_next  = state;
        load_shift  = 1'b0;
        write_now   = 1'b0;
        write_value = alu_value;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_shift && (shamt != 5'd0)) begin
                        load_shift = 1'b1;
                        state_next = SHIFT;
                    end else begin
                        write_now = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (cnt == 5'd1) begin
                    write_now   = 1'b1;
                    write_value = work_shifted;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
            load_shift = 1'b0;
            write_now  = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Serial shifter: load on accept, then step and count down
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= 5'd0;
            work        <= '0;
            sign_bit    <= 1'b0;
            shift_left  <= 1'b0;
            shift_arith <= 1'b0;
        end else if (flush) begin
            cnt <= 5'd0;
        end else if (load_shift) begin
            cnt         <= shamt;
            work        <= op_a;
            sign_bit    <= op_a[XLEN-1];
            shift_left  <= (func3 == 3'b001);
            shift_arith <= alt;
        end else if (state == SHIFT) begin
            cnt  <= cnt - 5'd1;
            work <= work_shifted;
        end
    end

    // Output slot: written on completion, drained by out_ready, killed by flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (write_now) begin
            out_valid <= 1'b1;
            result    <= write_value;
            zero      <= (write_value == '0);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
